btn_gesture: RTL and testbench



---
 rtl/btn_pkg.sv | 25 ++
 rtl/edge_detect.sv | 28 ++
 rtl/btn_gesture.sv | 155 +++++++++++++++
 tb/tb_btn_gesture.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and default timing for the button gesture classifier.
// Contents:
//   btn_state_t      - gesture FSM state encoding
//   DEF_*            - default timing for a 100 MHz clock
package btn_pkg;

  // Gesture FSM states
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    PRESS2 = 3'd3,
    LONG   = 3'd4
  } btn_state_t;

  // 0.5 s hold before long_press
  localparam int DEF_LONG_CYCLES   = 50_000_000;
  // 0.25 s maximum release-to-repress gap for a double tap
  localparam int DEF_GAP_CYCLES    = 25_000_000;
  // 0.1 s auto-repeat period while in long hold
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  // Timer width; every *_CYCLES value must be below 2**DEF_CNT_W
  localparam int DEF_CNT_W         = 26;

endpackage : btn_pkg

// File: rtl/edge_detect.sv
// Single-bit edge detector for a signal that is already synchronous to clk.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   d           - input level
//   rise, fall  - combinational edge flags (d against its registered copy)
//   d_q         - registered copy of d (0 in reset, so a high d after reset is a rise)
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic d_q
);

  // Previous-cycle copy of the input level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;
  assign fall = ~d & d_q;

endmodule : edge_detect

// File: rtl/btn_gesture.sv
// Classifies a debounced button level into one-cycle gesture events.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   btn_db         - debounced button level, 1 = pressed (synchronous to clk)
//   press_pulse    - every 0->1 of btn_db
//   release_pulse  - every 1->0 of btn_db
//   single_tap     - tap with no second press within GAP_CYCLES
//   double_tap     - second short press released
//   long_press     - hold reached LONG_CYCLES
//   repeat_pulse   - every REPEAT_CYCLES after long_press while held
//   busy           - FSM is not IDLE
// All outputs are registered; pulses are exactly one cycle wide.
module btn_gesture
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_db,
  output logic press_pulse,
  output logic release_pulse,
  output logic single_tap,
  output logic double_tap,
  output logic long_press,
  output logic repeat_pulse,
  output logic busy
);

  // Terminal counts: a timer holding LIM on an edge has counted *_CYCLES clocks
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_LIM  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  btn_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] rpt_r;
  logic             rise_s;
  logic             fall_s;
  logic             btn_q_unused_s;

  edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_db),
    .rise  (rise_s),
    .fall  (fall_s),
    .d_q   (btn_q_unused_s)
  );

  // Gesture FSM with its hold/gap timer, repeat timer and registered outputs.
  // Edges are tested before timeouts so an edge on the timeout clock wins,
  // and limits are tested before increments so the timers never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      cnt_r         <= CNT_ZERO;
      rpt_r         <= CNT_ZERO;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      single_tap    <= 1'b0;
      double_tap    <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      press_pulse   <= rise_s;
      release_pulse <= fall_s;
      single_tap    <= 1'b0;
      double_tap    <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      // busy follows the state being entered; transitions to/from IDLE override
      busy          <= (state_r != IDLE);

      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_r <= PRESS1;
            cnt_r   <= CNT_ZERO;
            busy    <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end

        PRESS1: begin
          if (fall_s) begin
            state_r <= GAP;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == LONG_LIM) begin
            state_r    <= LONG;
            long_press <= 1'b1;
            rpt_r      <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        GAP: begin
          if (rise_s) begin
            state_r <= PRESS2;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == GAP_LIM) begin
            state_r    <= IDLE;
            single_tap <= 1'b1;
            busy       <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        PRESS2: begin
          if (fall_s) begin
            state_r    <= IDLE;
            double_tap <= 1'b1;
            busy       <= 1'b0;
          end else if (cnt_r == LONG_LIM) begin
            // The earlier tap is dropped: this becomes a plain long hold
            state_r    <= LONG;
            long_press <= 1'b1;
            rpt_r      <= CNT_ZERO;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        LONG: begin
          if (fall_s) begin
            state_r <= IDLE;
            busy    <= 1'b0;
          end else if (rpt_r == RPT_LIM) begin
            repeat_pulse <= 1'b1;
            rpt_r        <= CNT_ZERO;
          end else begin
            rpt_r <= rpt_r + CNT_ONE;
          end
        end

        default: begin
          state_r <= IDLE;
          cnt_r   <= CNT_ZERO;
          rpt_r   <= CNT_ZERO;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule : btn_gesture

// File: tb/tb_btn_gesture.sv
// Directed bench for btn_gesture with LONG=8, GAP=5, REPEAT=3, CNT_W=4.
// Each step drives btn_db between edges, waits one rising edge and logs the
// outputs 1 ns later as {press, release, single, double, long, repeat, busy}.
// Index k of the log is the edge at which that step's btn_db value is sampled.
module tb_btn_gesture;

  logic clk;
  logic rst_n;
  logic btn_db;
  logic press_pulse;
  logic release_pulse;
  logic single_tap;
  logic double_tap;
  logic long_press;
  logic repeat_pulse;
  logic busy;

  int n_chk;
  int n_bad;
  int k;
  logic [6:0] log_v [0:63];

  btn_gesture #(
    .LONG_CYCLES   (8),
    .GAP_CYCLES    (5),
    .REPEAT_CYCLES (3),
    .CNT_W         (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_db        (btn_db),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .single_tap    (single_tap),
    .double_tap    (double_tap),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic b);
    btn_db = b;
    @(posedge clk);
    #1;
    log_v[k] = {press_pulse, release_pulse, single_tap, double_tap,
                long_press, repeat_pulse, busy};
    k++;
  endtask

  task automatic test_reset();
    logic [6:0] exp_v;
    rst_n = 1'b0;
    k = 0;
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (log_v[i] !== 7'b0000000) begin
        n_bad++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, log_v[i], 7'b0000000);
      end
    end
    rst_n = 1'b1;
    k = 0;
    step(1'b1);
    for (int i = 0; i < 9; i++) step(1'b0);
    // rise at 0, fall at 1, single tap 5 clocks after release
    for (int i = 0; i < 10; i++) begin
      exp_v = 7'b0000000;
      if (i == 0) exp_v[6] = 1'b1;
      if (i == 1) exp_v[5] = 1'b1;
      if (i == 6) exp_v[4] = 1'b1;
      if (i < 6)  exp_v[0] = 1'b1;
      n_chk++;
      if (log_v[i] !== exp_v) begin
        n_bad++;
        $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, log_v[i], exp_v);
      end
    end
  endtask

  task automatic test_single_tap();
    logic [6:0] exp_v;
    k = 0;
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 10; i++) step(1'b0);
    for (int i = 0; i < 13; i++) begin
      exp_v = 7'b0000000;
      if (i == 0) exp_v[6] = 1'b1;
      if (i == 3) exp_v[5] = 1'b1;
      if (i == 8) exp_v[4] = 1'b1;
      if (i < 8)  exp_v[0] = 1'b1;
      n_chk++;
      if (log_v[i] !== exp_v) begin
        n_bad++;
        $display("FAIL single_tap cyc=%0d got=%b exp=%b", i, log_v[i], exp_v);
      end
    end
  endtask

  task automatic test_double_tap();
    logic [6:0] exp_v;
    k = 0;
    step(1'b1); step(1'b1); step(1'b0); step(1'b0);
    step(1'b1); step(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0);
    for (int i = 0; i < 14; i++) begin
      exp_v = 7'b0000000;
      if (i == 0 || i == 4) exp_v[6] = 1'b1;
      if (i == 2 || i == 6) exp_v[5] = 1'b1;
      if (i == 6) exp_v[3] = 1'b1;
      if (i < 6)  exp_v[0] = 1'b1;
      n_chk++;
      if (log_v[i] !== exp_v) begin
        n_bad++;
        $display("FAIL double_tap cyc=%0d got=%b exp=%b", i, log_v[i], exp_v);
      end
    end
  endtask

  task automatic test_long_repeat();
    logic [6:0] exp_v;
    k = 0;
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    for (int i = 0; i < 25; i++) begin
      exp_v = 7'b0000000;
      if (i == 0)  exp_v[6] = 1'b1;
      if (i == 20) exp_v[5] = 1'b1;
      if (i == 8)  exp_v[2] = 1'b1;
      if (i == 11 || i == 14 || i == 17) exp_v[1] = 1'b1;
      if (i < 20)  exp_v[0] = 1'b1;
      n_chk++;
      if (log_v[i] !== exp_v) begin
        n_bad++;
        $display("FAIL long_repeat cyc=%0d got=%b exp=%b", i, log_v[i], exp_v);
      end
    end
  endtask

  task automatic test_fall_at_long_edge();
    logic [6:0] exp_v;
    k = 0;
    for (int i = 0; i < 8; i++) step(1'b1);
    for (int i = 0; i < 9; i++) step(1'b0);
    for (int i = 0; i < 17; i++) begin
      exp_v = 7'b0000000;
      if (i == 0)  exp_v[6] = 1'b1;
      if (i == 8)  exp_v[5] = 1'b1;
      if (i == 13) exp_v[4] = 1'b1;
      if (i < 13)  exp_v[0] = 1'b1;
      n_chk++;
      if (log_v[i] !== exp_v) begin
        n_bad++;
        $display("FAIL fall_on_long_edge cyc=%0d got=%b exp=%b", i, log_v[i], exp_v);
      end
    end
  endtask

  task automatic test_rise_at_gap_edge();
    logic [6:0] exp_v;
    k = 0;
    step(1'b1);
    for (int i = 0; i < 5; i++) step(1'b0);
    step(1'b1); step(1'b1);
    for (int i = 0; i < 8; i++) step(1'b0);
    for (int i = 0; i < 16; i++) begin
      exp_v = 7'b0000000;
      if (i == 0 || i == 6) exp_v[6] = 1'b1;
      if (i == 1 || i == 8) exp_v[5] = 1'b1;
      if (i == 8) exp_v[3] = 1'b1;
      if (i < 8)  exp_v[0] = 1'b1;
      n_chk++;
      if (log_v[i] !== exp_v) begin
        n_bad++;
        $display("FAIL rise_on_gap_edge cyc=%0d got=%b exp=%b", i, log_v[i], exp_v);
      end
    end
  endtask

  task automatic test_reset_mid_gap();
    logic [6:0] exp_v;
    logic [6:0] now_v;
    k = 0;
    step(1'b1); step(1'b0); step(1'b0); step(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    now_v = {press_pulse, release_pulse, single_tap, double_tap,
             long_press, repeat_pulse, busy};
    n_chk++;
    if (now_v !== 7'b0000000) begin
      n_bad++;
      $display("FAIL reset_mid_gap_async got=%b exp=%b", now_v, 7'b0000000);
    end
    step(1'b0); step(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0);
    for (int i = 0; i < 16; i++) begin
      exp_v = 7'b0000000;
      if (i == 0) exp_v[6] = 1'b1;
      if (i == 1) exp_v[5] = 1'b1;
      if (i < 4)  exp_v[0] = 1'b1;
      n_chk++;
      if (log_v[i] !== exp_v) begin
        n_bad++;
        $display("FAIL reset_mid_gap cyc=%0d got=%b exp=%b", i, log_v[i], exp_v);
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_bad  = 0;
    k      = 0;
    rst_n  = 1'b0;
    btn_db = 1'b1;
    test_reset();
    test_single_tap();
    test_double_tap();
    test_long_repeat();
    test_fall_at_long_edge();
    test_rise_at_gap_edge();
    test_reset_mid_gap();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule : tb_btn_gesture
